// File: rtl/torpedo_launch_ctrl.sv
// Central fire controller: debounces the fire button on vsync, launches a free torpedo slot
// round-robin, waits for its flight acknowledge and enforces a frame-based cooldown.
module torpedo_launch_ctrl #(
    parameter int unsigned N_TORP          = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned AUTO_REPEAT     = 0,
    parameter int unsigned ACK_TIMEOUT     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             vsync,
    input  logic                             fire_btn,
    input  logic                             ship_alive,
    input  logic [N_TORP-1:0]                slot_busy,
    output logic [N_TORP-1:0]                launch,
    output logic                             fire_deb,
    output logic [$clog2(N_TORP+1)-1:0]      active_count,
    output logic                             no_slot,
    output logic                             ack_err,
    output logic [15:0]                      launch_total
);

    localparam int unsigned IDX_W = $clog2(N_TORP);
    localparam int unsigned CNT_W = $clog2(N_TORP + 1);
    // +2 keeps both counters at least one bit wide when the parameter is 0
    localparam int unsigned CD_W  = $clog2(COOLDOWN_FRAMES + 2);
    localparam int unsigned AK_W  = $clog2(ACK_TIMEOUT + 2);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StLaunch,
        StAck,
        StCooldown,
        StRelease
    } state_t;

    state_t             state;
    logic               deb_test;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [CD_W-1:0]    cd_cnt;
    logic [AK_W-1:0]    ack_cnt;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic [CNT_W-1:0]   busy_cnt;

    // First free slot at or after rr_ptr, wrapping around the pool
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < int'(N_TORP); k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % int'(N_TORP));
            if (!found && !slot_busy[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int k = 0; k < int'(N_TORP); k++) begin
            busy_cnt = busy_cnt + CNT_W'(slot_busy[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            deb_test     <= 1'b0;
            fire_deb     <= 1'b0;
            rr_ptr       <= '0;
            idx          <= '0;
            cd_cnt       <= '0;
            ack_cnt      <= '0;
            launch       <= '0;
            no_slot      <= 1'b0;
            ack_err      <= 1'b0;
            active_count <= '0;
            launch_total <= '0;
        end else begin
            launch       <= '0;
            no_slot      <= 1'b0;
            ack_err      <= 1'b0;
            active_count <= busy_cnt;

            if (vsync) begin
                fire_deb <= deb_test;
                deb_test <= 1'b1;
            end else begin
                deb_test <= deb_test & fire_btn;
            end

            unique case (state)
                StIdle: begin
                    if (fire_deb && ship_alive) state <= StSelect;
                end
                StSelect: begin
                    if (!ship_alive) begin
                        state <= StRelease;
                    end else if (found) begin
                        idx    <= pick;
                        launch <= {{(N_TORP-1){1'b0}}, 1'b1} << pick;
                        state  <= StLaunch;
                    end else begin
                        no_slot <= 1'b1;
                        state   <= StRelease;
                    end
                end
                StLaunch: begin
                    rr_ptr  <= (idx == IDX_W'(N_TORP - 1)) ? '0 : idx + 1'b1;
                    if (launch_total != 16'hFFFF) launch_total <= launch_total + 16'd1;
                    ack_cnt <= AK_W'(1);
                    state   <= StAck;
                end
                StAck: begin
                    if (slot_busy[idx]) begin
                        cd_cnt <= CD_W'(COOLDOWN_FRAMES);
                        state  <= StCooldown;
                    end else if (int'(ack_cnt) + 1 >= int'(ACK_TIMEOUT)) begin
                        ack_err <= 1'b1;
                        cd_cnt  <= CD_W'(COOLDOWN_FRAMES);
                        state   <= StCooldown;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                StCooldown: begin
                    if (cd_cnt == '0) begin
                        if ((AUTO_REPEAT != 0) && fire_deb && ship_alive) state <= StSelect;
                        else state <= StRelease;
                    end else if (vsync) begin
                        cd_cnt <= cd_cnt - 1'b1;
                    end
                end
                StRelease: begin
                    if (!fire_deb) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_torpedo_launch_ctrl.sv
// Directed bench for torpedo_launch_ctrl: one instance with default parameters and one
// with auto-repeat and a 3-frame cooldown, sharing clock, reset, vsync and button.
module tb_torpedo_launch_ctrl;

    localparam int P = 10;  // clocks per frame

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vsync = 1'b0;
    logic fire_btn = 1'b0;
    logic ship_alive = 1'b1;
    logic [3:0] slot_busy_a = '0, slot_busy_b = '0;
    logic [3:0] busy_a = '0, busy_b = '0, prev_a = '0, prev_b = '0, static_mask = '0;
    bit echo_en = 1'b0, clr_en = 1'b0;

    logic [3:0]  launch_a, launch_b;
    logic        fire_deb_a, fire_deb_b;
    logic [2:0]  ac_a, ac_b;
    logic        no_slot_a, no_slot_b, ack_err_a, ack_err_b;
    logic [15:0] total_a, total_b;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    torpedo_launch_ctrl dut (
        .clk(clk), .reset(reset), .vsync(vsync), .fire_btn(fire_btn), .ship_alive(ship_alive),
        .slot_busy(slot_busy_a), .launch(launch_a), .fire_deb(fire_deb_a),
        .active_count(ac_a), .no_slot(no_slot_a), .ack_err(ack_err_a), .launch_total(total_a)
    );

    torpedo_launch_ctrl #(
        .N_TORP(4), .COOLDOWN_FRAMES(3), .AUTO_REPEAT(1), .ACK_TIMEOUT(4)
    ) dut_ar (
        .clk(clk), .reset(reset), .vsync(vsync), .fire_btn(fire_btn), .ship_alive(ship_alive),
        .slot_busy(slot_busy_b), .launch(launch_b), .fire_deb(fire_deb_b),
        .active_count(ac_b), .no_slot(no_slot_b), .ack_err(ack_err_b), .launch_total(total_b)
    );

    always #5 clk = ~clk;

    // Advance one clock; afterwards outputs are stable and inputs for this cycle are set.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        vsync = (cyc % P == 0);
        if (clr_en && vsync) begin
            busy_a = '0;
            busy_b = '0;
        end
        if (echo_en) begin
            busy_a = busy_a | prev_a;
            busy_b = busy_b | prev_b;
        end
        prev_a = launch_a;
        prev_b = launch_b;
        slot_busy_a = busy_a | static_mask;
        slot_busy_b = busy_b | static_mask;
    endtask

    task automatic reset_all();
        reset = 1'b1;
        fire_btn = 1'b0;
        ship_alive = 1'b1;
        echo_en = 1'b0;
        clr_en = 1'b0;
        static_mask = '0;
        busy_a = '0;
        busy_b = '0;
        prev_a = '0;
        prev_b = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_launch(input int bound, output logic [3:0] seen);
        seen = '0;
        for (int i = 0; i < bound && seen == 4'b0; i++) begin
            tick();
            seen = launch_a;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({launch_a, fire_deb_a, ac_a, no_slot_a, ack_err_a, total_a} !== 26'd0) begin
            errors++;
            $display("FAIL reset_a: outputs %0h want 0",
                     {launch_a, fire_deb_a, ac_a, no_slot_a, ack_err_a, total_a});
        end
        checks++;
        if ({launch_b, fire_deb_b, ac_b, no_slot_b, ack_err_b, total_b} !== 26'd0) begin
            errors++;
            $display("FAIL reset_b: outputs %0h want 0",
                     {launch_b, fire_deb_b, ac_b, no_slot_b, ack_err_b, total_b});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({launch_a, fire_deb_a, ac_a, total_a} !== 24'd0) begin
            errors++;
            $display("FAIL idle_after_reset: outputs %0h want 0",
                     {launch_a, fire_deb_a, ac_a, total_a});
        end
    endtask

    task automatic test_debounce();
        int i;
        reset_all();
        echo_en = 1'b1;
        i = 0;
        do begin
            tick();
            i++;
        end while (!vsync && i < 2 * P);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) fire_btn = 1'b1;
            if (k == 20) fire_btn = 1'b0;
        end
        checks++;
        if (fire_deb_a !== 1'b0) begin
            errors++;
            $display("FAIL deb_before_2nd_vsync: fire_deb=%b want 0", fire_deb_a);
        end
        tick();
        checks++;
        if (fire_deb_a !== 1'b1) begin
            errors++;
            $display("FAIL deb_after_2nd_vsync: fire_deb=%b want 1", fire_deb_a);
        end
        checks++;
        if (launch_a !== 4'b0) begin
            errors++;
            $display("FAIL launch_early: launch=%b want 0000", launch_a);
        end
        tick();
        tick();
        checks++;
        if (launch_a !== 4'b0001) begin
            errors++;
            $display("FAIL launch_latency: launch=%b want 0001", launch_a);
        end
        tick();
        checks++;
        if (launch_a !== 4'b0 || total_a !== 16'd1) begin
            errors++;
            $display("FAIL launch_pulse_total: launch=%b total=%0d want 0000/1", launch_a, total_a);
        end
        tick();
        checks++;
        if (ac_a !== 3'd1) begin
            errors++;
            $display("FAIL active_count: got %0d want 1", ac_a);
        end
    endtask

    task automatic test_glitch();
        bit saw_deb, saw_launch;
        reset_all();
        echo_en = 1'b1;
        saw_deb = 1'b0;
        saw_launch = 1'b0;
        for (int k = 0; k < 5 * P; k++) begin
            tick();
            fire_btn = ((cyc % P) != 5);
            if (fire_deb_a) saw_deb = 1'b1;
            if (launch_a != 4'b0) saw_launch = 1'b1;
        end
        fire_btn = 1'b0;
        checks++;
        if (saw_deb !== 1'b0) begin
            errors++;
            $display("FAIL glitch_deb: fire_deb seen=%b want 0", saw_deb);
        end
        checks++;
        if (saw_launch !== 1'b0) begin
            errors++;
            $display("FAIL glitch_launch: launch seen=%b want 0", saw_launch);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seen;
        logic [3:0] exp;
        int ns_cnt, l_cnt;
        reset_all();
        echo_en = 1'b1;
        exp = 4'b0001;
        for (int p = 0; p < 4; p++) begin
            fire_btn = 1'b1;
            wait_launch(4 * P, seen);
            checks++;
            if (seen !== exp) begin
                errors++;
                $display("FAIL rr_launch%0d: launch=%b want %b", p, seen, exp);
            end
            exp = exp << 1;
            fire_btn = 1'b0;
            repeat (12 * P) tick();
        end
        checks++;
        if (total_a !== 16'd4 || ac_a !== 3'd4) begin
            errors++;
            $display("FAIL rr_totals: total=%0d active=%0d want 4/4", total_a, ac_a);
        end
        fire_btn = 1'b1;
        ns_cnt = 0;
        l_cnt = 0;
        for (int k = 0; k < 4 * P; k++) begin
            tick();
            if (no_slot_a) ns_cnt++;
            if (launch_a != 4'b0) l_cnt++;
        end
        fire_btn = 1'b0;
        checks++;
        if (ns_cnt !== 1) begin
            errors++;
            $display("FAIL no_slot_pulse: pulses=%0d want 1", ns_cnt);
        end
        checks++;
        if (l_cnt !== 0) begin
            errors++;
            $display("FAIL no_slot_launch: launches=%0d want 0", l_cnt);
        end
    endtask

    task automatic test_cooldown();
        logic [3:0] vals[5];
        int at[5];
        int vs[5];
        int n, vcount;
        logic [3:0] exp;
        reset_all();
        echo_en = 1'b1;
        clr_en = 1'b1;
        fire_btn = 1'b1;
        n = 0;
        vcount = 0;
        for (int k = 0; k < 25 * P && n < 5; k++) begin
            tick();
            if (vsync) vcount++;
            if (launch_b != 4'b0) begin
                vals[n] = launch_b;
                at[n] = cyc;
                vs[n] = vcount;
                vcount = 0;
                n++;
            end
        end
        fire_btn = 1'b0;
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL cd_count: launches=%0d want 5", n);
        end
        exp = 4'b0001;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (vals[i] !== exp) begin
                errors++;
                $display("FAIL cd_launch%0d: launch=%b want %b", i, vals[i], exp);
            end
            exp = (exp == 4'b1000) ? 4'b0001 : exp << 1;
            if (i > 0) begin
                checks++;
                if (vs[i] !== 3 || at[i] - at[i-1] !== 3 * P) begin
                    errors++;
                    $display("FAIL cd_spacing%0d: vsyncs=%0d gap=%0d want 3/%0d",
                             i, vs[i], at[i] - at[i-1], 3 * P);
                end
            end
        end
    endtask

    task automatic test_ack_timeout();
        logic [3:0] seen;
        reset_all();
        fire_btn = 1'b1;
        wait_launch(4 * P, seen);
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL ack_launch: launch=%b want 0001", seen);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (ack_err_a !== (k == 4)) begin
                errors++;
                $display("FAIL ack_err_at_%0d: ack_err=%b want %b", k, ack_err_a, (k == 4));
            end
        end
        fire_btn = 1'b0;
        repeat (11 * P) tick();
        fire_btn = 1'b1;
        wait_launch(4 * P, seen);
        fire_btn = 1'b0;
        checks++;
        if (seen !== 4'b0010) begin
            errors++;
            $display("FAIL ack_next_launch: launch=%b want 0010", seen);
        end
    endtask

    task automatic test_reset_ship();
        logic [3:0] seen;
        bit got;
        int l_cnt;
        reset_all();
        static_mask = 4'b0100;
        fire_btn = 1'b1;
        wait_launch(4 * P, seen);
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (fire_deb_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_fire_deb: got %b want 0", fire_deb_a);
        end
        checks++;
        if (total_a !== 16'd0) begin
            errors++;
            $display("FAIL rst_total: got %0d want 0", total_a);
        end
        checks++;
        if (ac_a !== 3'd0) begin
            errors++;
            $display("FAIL rst_active: got %0d want 0", ac_a);
        end
        checks++;
        if ({launch_a, ack_err_a, no_slot_a} !== 6'd0) begin
            errors++;
            $display("FAIL rst_pulses: got %b want 0", {launch_a, ack_err_a, no_slot_a});
        end
        tick();
        reset = 1'b0;
        wait_launch(4 * P, seen);
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL rst_relaunch: launch=%b want 0001", seen);
        end
        fire_btn = 1'b0;

        reset_all();
        echo_en = 1'b1;
        fire_btn = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 * P && !got; i++) begin
            tick();
            if (fire_deb_a) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL ship_deb_timeout: fire_deb=%b want 1", got);
        end
        tick();
        ship_alive = 1'b0;
        tick();
        ship_alive = 1'b1;
        l_cnt = 0;
        for (int k = 0; k < 3 * P; k++) begin
            tick();
            if (launch_a != 4'b0 || no_slot_a) l_cnt++;
        end
        checks++;
        if (l_cnt !== 0) begin
            errors++;
            $display("FAIL ship_abort: launches=%0d want 0", l_cnt);
        end
        fire_btn = 1'b0;
        repeat (3 * P) tick();
        fire_btn = 1'b1;
        wait_launch(4 * P, seen);
        fire_btn = 1'b0;
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL ship_repress: launch=%b want 0001", seen);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_round_robin();
        test_cooldown();
        test_ack_timeout();
        test_reset_ship();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
